// File: rtl/double2long.sv
// double2long: 3-cycle binary64 to signed/unsigned 32/64-bit integer converter, truncating toward zero.
module double2long (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ena,
  input  logic        i_signed,
  input  logic        i_w32,
  input  logic [63:0] i_a,
  output logic [63:0] o_res,
  output logic        o_overflow,
  output logic        o_underflow,
  output logic        o_valid,
  output logic        o_busy
);
  logic        busy_q, busy_d, sign_q, w32_q, signed_q, nan_q, inf_q, zero_q;
  logic        ovf_q, ovf_d, udf_q, udf_d, oovf_q, oovf_d, oudf_q, oudf_d;
  logic [2:0]  ena_q;
  logic [10:0] exp_q, lim, lsh, rsh;
  logic [52:0] mant_q;
  logic [63:0] align_q, align_d, res_q, res_d, mag, val, r64, smax, smin;
  logic        accept, frac_nz;
  assign accept  = i_ena & ~busy_q;
  assign frac_nz = |mant_q[51:0];
  assign lim     = w32_q ? 11'd1054 : 11'd1086;
  assign lsh     = exp_q - 11'd1075;
  assign rsh     = 11'd1075 - exp_q;
  assign smax    = w32_q ? 64'h0000_0000_7FFF_FFFF : 64'h7FFF_FFFF_FFFF_FFFF;
  assign smin    = w32_q ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign mag     = zero_q ? 64'd0 : align_q;
  assign val     = (sign_q & signed_q) ? -mag : mag;
  always_comb begin
    busy_d  = accept ? 1'b1 : ena_q[2] ? 1'b0 : busy_q;
    align_d = exp_q >= 11'd1075 ? (lsh < 11'd64 ? {11'd0, mant_q} << lsh[5:0] : 64'd0)
                                : (rsh < 11'd64 ? {11'd0, mant_q} >> rsh[5:0] : 64'd0);
    // exponent lim is e = N-1; only -2^(N-1) exactly is legal there when negative
    ovf_d   = signed_q ? (exp_q > lim) | ((exp_q == lim) & (~sign_q | frac_nz))
                       : nan_q | (~sign_q & (exp_q > lim));
    udf_d   = ~signed_q & sign_q & ~zero_q & ~nan_q;
    r64     = signed_q ? (ovf_q ? ((sign_q & ~nan_q) ? smin : smax) : val)
                       : (ovf_q ? 64'hFFFF_FFFF_FFFF_FFFF : udf_q ? 64'd0 : val);
    res_d   = ena_q[1] ? (w32_q ? {{32{r64[31]}}, r64[31:0]} : r64) : res_q;
    oovf_d  = ena_q[1] ? ovf_q : oovf_q;
    oudf_d  = ena_q[1] ? udf_q : oudf_q;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      busy_q <= 1'b0; ena_q <= 3'd0; sign_q <= 1'b0; exp_q <= 11'd0; mant_q <= 53'd0;
      w32_q <= 1'b0; signed_q <= 1'b0; nan_q <= 1'b0; inf_q <= 1'b0; zero_q <= 1'b0;
      align_q <= 64'd0; ovf_q <= 1'b0; udf_q <= 1'b0; res_q <= 64'd0;
      oovf_q <= 1'b0; oudf_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      ena_q  <= {ena_q[1:0], accept};
      if (accept) begin
        sign_q   <= i_a[63];
        exp_q    <= i_a[62:52];
        mant_q   <= {1'b1, i_a[51:0]};
        w32_q    <= i_w32;
        signed_q <= i_signed;
        nan_q    <= (&i_a[62:52]) & (|i_a[51:0]);
        inf_q    <= (&i_a[62:52]) & ~(|i_a[51:0]);
        zero_q   <= i_a[62:52] < 11'd1023;
      end
      if (ena_q[0]) begin
        align_q <= align_d;
        ovf_q   <= ovf_d;
        udf_q   <= udf_d;
      end
      res_q  <= res_d;
      oovf_q <= oovf_d;
      oudf_q <= oudf_d;
    end
  end
  assign o_res       = res_q;
  assign o_overflow  = oovf_q;
  assign o_underflow = oudf_q;
  assign o_valid     = ena_q[2];
  assign o_busy      = busy_q;
endmodule

// File: doc/double2long.md
# double2long

Pipelined IEEE-754 binary64 to integer converter for the River FPU (fpu_d); the inverse of the long-to-double unit. It covers the RV64D FCVT.L.D, FCVT.LU.D, FCVT.W.D and FCVT.WU.D conversions, truncating toward zero (RTZ only). It sits beside the other fpu_d units, is started by the FPU dispatcher with a one-cycle enable, and returns a 64-bit integer register value after a fixed 3-cycle latency.

## Interface
- No parameters.
- i_clk  in  1  core clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_ena  in  1  start pulse; sampled only while o_busy=0.
- i_signed  in  1  1 selects a signed destination (L/W), 0 selects unsigned (LU/WU).
- i_w32  in  1  1 selects a 32-bit destination (W/WU), 0 selects 64-bit (L/LU).
- i_a  in  64  binary64 operand.
- o_res  out  64  integer result; in 32-bit mode the value is sign-extended from bit 31.
- o_overflow  out  1  result saturated high or low because the magnitude was out of range, or the operand was NaN or ±Inf.
- o_underflow  out  1  unsigned mode only: negative operand whose truncated value is nonzero; the result is 0.
- o_valid  out  1  one-cycle pulse; o_res and the flags are valid in this cycle.
- o_busy  out  1  a conversion is in flight.

## Operation
- Registers: busy, ena[2:0] (enable shift), sign, exp[10:0], mant[52:0], w32, op_signed, nan, inf, zero, mantAlign[63:0], ovf, udf, result[63:0].
- Stage 1 (edge where i_ena=1 and busy=0):
  - Latch the fields of i_a and the mode bits.
  - mant = {1, frac}.
  - zero = 1 when exp < 1023 (this covers zeros, denormals and |x| < 1).
  - nan = 1 when exp = 0x7FF and frac != 0; inf = 1 when exp = 0x7FF and frac = 0.
- Stage 2 (alignment):
  - If exp >= 1075: mantAlign = mant << (exp−1075). If exp < 1075: mantAlign = mant >> (1075−exp).
  - Shift amounts of 64 or more yield 0 or the saturation path; no wrap-around.
  - Let e = exp−1023 and N = 64 (i_w32=0) or 32 (i_w32=1).
  - Signed overflow: e > N−1, or e = N−1 with sign=0, or e = N−1 with sign=1 and frac != 0.
  - Consequence: exactly −2^(N−1) is legal and must not set the flag.
  - Unsigned overflow: sign=0 and e > N−1.
  - Unsigned underflow: sign=1 and zero=0 (includes −Inf).
  - NaN or +Inf sets ovf. −Inf sets ovf in signed mode and udf in unsigned mode.
- Stage 3 (result):
  - In-range values: magnitude = mantAlign, or 0 when zero=1. Negate it (two's complement) when sign=1 and signed mode.
  - Signed saturation: ovf with sign=0 or NaN gives 2^(N−1)−1; ovf with sign=1 gives −2^(N−1).
  - Unsigned saturation: ovf gives 2^N−1; udf gives 0.
  - Negative inputs with zero=1 give 0 with no flag in both modes.
  - When i_w32=1, bits 63:32 are replicated from bit 31 in all cases. For example, WU saturation gives 0xFFFF_FFFF_FFFF_FFFF.
- o_res, o_overflow and o_underflow hold their values until the next o_valid.

## Timing
- Cycle 0: i_ena=1 with o_busy=0. Cycles 1–3: o_busy=1. Cycle 3: o_valid=1. Cycle 4: o_busy=0 and the earliest next accepted i_ena.
- Throughput is one conversion per 4 cycles.
- An i_ena raised while o_busy=1 is ignored: no queuing and no effect on the conversion in flight.
- i_a and the mode bits are sampled only in cycle 0 and may change afterwards.
- Reset values: o_res=0, o_overflow=0, o_underflow=0, o_valid=0, o_busy=0; all internal registers are 0.
- Reset asserted mid-conversion aborts it: no o_valid is produced, and a new i_ena is accepted in the first cycle after reset deasserts.

## Test plan
- 0x3FF8000000000000 (1.5), signed, 64-bit -> o_res=0x0000000000000001, o_valid in cycle 3, o_busy high in cycles 1–3, no flags.
- 0xC006000000000000 (−2.75), signed, 64-bit -> 0xFFFFFFFFFFFFFFFE; the same operand unsigned -> 0 with o_underflow=1. 0xBFE0000000000000 (−0.5), unsigned -> 0, no flags.
- 0x43E0000000000000 (2^63):
  - signed -> 0x7FFFFFFFFFFFFFFF, o_overflow=1.
  - unsigned -> 0x8000000000000000, no flags.
  - 0xC3E0000000000000 (−2^63), signed -> 0x8000000000000000, no flags.
- 0x41E65A0BC0000000 (3e9):
  - WU -> 0xFFFFFFFFB2D05E00, no flags.
  - W -> 0x000000007FFFFFFF, o_overflow=1.
- 0x7FF8000000000000 (NaN), signed -> 0x7FFFFFFFFFFFFFFF, o_overflow=1. 0xFFF0000000000000 (−Inf): signed -> 0x8000000000000000 with o_overflow=1; WU -> 0 with o_underflow=1.
- Control boundaries:
  - A second i_ena in cycles 1–3 with a different i_a is ignored, and the first result is unchanged.
  - i_rst pulsed in cycle 2 -> no o_valid, o_busy=0, outputs 0.
  - Back-to-back i_ena in cycles 0 and 4 -> o_valid in cycles 3 and 7.
